muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: shift-add multiply and restoring
// divide at one bit per cycle, with a one-cycle sign-fixup state before write-back.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       fncode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 div_zero_q, div_zero_d;
    logic                 done_q, done_d;

    logic                 fn_mul, fn_div, fn_signed;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH-1:0]     mul_addend;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_ok;
    logic [WIDTH-1:0]     div_sub, div_rem;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]     quo, rem;

    assign fn_mul    = (fncode == FN_MULT) || (fncode == FN_MULTU);
    assign fn_div    = (fncode == FN_DIV)  || (fncode == FN_DIVU);
    assign fn_signed = (fncode == FN_MULT) || (fncode == FN_DIV);
    assign a_neg     = fn_signed && op_a[WIDTH-1];
    assign b_neg     = fn_signed && op_b[WIDTH-1];
    assign a_mag     = a_neg ? -op_a : op_a;
    assign b_mag     = b_neg ? -op_b : op_b;

    // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}.
    assign mul_addend = acc_q[0] ? m_q : '0;
    assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    assign mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

    // The successful difference is always below the divisor, so W-bit subtraction suffices.
    assign div_shift  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ok     = div_shift >= {1'b0, m_q};
    assign div_sub    = div_shift[WIDTH-1:0] - m_q;
    assign div_rem    = div_ok ? div_sub : div_shift[WIDTH-1:0];
    assign div_next   = {div_rem, acc_q[WIDTH-2:0], div_ok};

    assign prod_fix   = neg_res_q ? -acc_q : acc_q;
    assign quo        = acc_q[WIDTH-1:0];
    assign rem        = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        m_d        = m_q;
        a_raw_d    = a_raw_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    if (fn_mul || fn_div) begin
                        state_d    = RUN;
                        cnt_d      = '0;
                        m_d        = fn_mul ? a_mag : b_mag;
                        acc_d      = {{WIDTH{1'b0}}, (fn_mul ? b_mag : a_mag)};
                        a_raw_d    = op_a;
                        is_div_d   = fn_div;
                        neg_res_d  = a_neg ^ b_neg;
                        neg_rem_d  = a_neg;
                        div_zero_d = (op_b == '0);
                    end else if (fncode == FN_MTHI) begin
                        hi_d   = op_a;
                        done_d = 1'b1;
                    end else if (fncode == FN_MTLO) begin
                        lo_d   = op_a;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cancel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    if (cnt_q == LAST) begin
                        state_d = FIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (div_zero_q && is_div_q) begin
                        hi_d = a_raw_q;
                        lo_d = '1;
                    end else if (is_div_q) begin
                        lo_d = neg_res_q ? -quo : quo;
                        hi_d = neg_rem_q ? -rem : rem;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            m_q        <= '0;
            a_raw_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            m_q        <= m_d;
            a_raw_q    <= a_raw_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven check of muldiv_unit at WIDTH=32 plus hand-written
// sequences for cancel, ignored starts, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef struct {
        logic [5:0]   fn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expHi;
        logic [W-1:0] expLo;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [5:0]   fncode;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cancel;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int           testsRun = 0;
    int           testsFailed = 0;
    logic [W-1:0] modelHi = '0;
    logic [W-1:0] modelLo = '0;
    vec_t         vecs[13];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .fncode (fncode),
        .op_a   (op_a),
        .op_b   (op_b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present a start for one edge, then scramble the operands since they are don't-care afterwards.
    task automatic applyStimulus(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
        start  = 1'b1;
        fncode = fn;
        op_a   = a;
        op_b   = b;
        tick();
        start  = 1'b0;
        op_a   = $urandom;
        op_b   = $urandom;
    endtask

    task automatic waitDone(input string name, input int expCycles, input logic [W-1:0] expHi, input logic [W-1:0] expLo);
        int   busyCycles = 0;
        logic earlyDone  = 1'b0;
        while (busy && busyCycles < 60) begin
            busyCycles++;
            if (done) earlyDone = 1'b1;
            tick();
        end
        checkOutput({name, " busy cycles"}, 64'(busyCycles), 64'(expCycles));
        checkOutput({name, " done while busy"}, 64'(earlyDone), 64'd0);
        checkOutput({name, " done"}, 64'(done), 64'd1);
        checkOutput({name, " hi"}, 64'(hi), 64'(expHi));
        checkOutput({name, " lo"}, 64'(lo), 64'(expLo));
        modelHi = expHi;
        modelLo = expLo;
    endtask

    task automatic noDoneFor(input string name, input int cycles);
        logic sawDone = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (done) sawDone = 1'b1;
            tick();
        end
        checkOutput({name, " no done"}, 64'(sawDone), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{FN_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{FN_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[5]  = '{FN_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[6]  = '{FN_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[7]  = '{FN_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[8]  = '{FN_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[9]  = '{FN_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{FN_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[11] = '{FN_MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[12] = '{FN_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};

        rst_n  = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        fncode = '0;
        op_a   = '0;
        op_b   = '0;
        tick();
        tick();
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        // Table vectors; the first start lands on the first edge after reset release.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].fn, vecs[i].a, vecs[i].b);
            waitDone($sformatf("vec%0d", i), 33, vecs[i].expHi, vecs[i].expLo);
            tick();
            checkOutput($sformatf("vec%0d done pulse width", i), 64'(done), 64'd0);
        end

        applyStimulus(6'b100000, 32'h1, 32'h2);
        checkOutput("badfn busy", 64'(busy), 64'd0);
        tick();
        checkOutput("badfn done", 64'(done), 64'd0);
        checkOutput("badfn hi", 64'(hi), 64'(modelHi));
        checkOutput("badfn lo", 64'(lo), 64'(modelLo));

        // MTLO then a multiply issued in the MTLO done cycle, then MTHI in the multiply done cycle.
        applyStimulus(FN_MTLO, 32'h00001234, 32'h0);
        checkOutput("mtlo lo", 64'(lo), 64'h1234);
        checkOutput("mtlo busy", 64'(busy), 64'd0);
        checkOutput("mtlo done", 64'(done), 64'd1);
        applyStimulus(FN_MULTU, 32'd3, 32'd4);
        waitDone("multu after mtlo", 33, 32'd0, 32'd12);
        applyStimulus(FN_MTHI, 32'h0000CAFE, 32'h0);
        checkOutput("mthi hi", 64'(hi), 64'hCAFE);
        checkOutput("mthi done", 64'(done), 64'd1);
        modelHi = 32'h0000CAFE;
        tick();

        start  = 1'b1;
        cancel = 1'b1;
        fncode = FN_MTLO;
        op_a   = 32'h5555;
        tick();
        fncode = FN_MULTU;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        checkOutput("start+cancel busy", 64'(busy), 64'd0);
        checkOutput("start+cancel done", 64'(done), 64'd0);
        checkOutput("start+cancel lo", 64'(lo), 64'(modelLo));

        applyStimulus(FN_MULTU, 32'd5, 32'd6);
        repeat (9) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checkOutput("cancel run busy", 64'(busy), 64'd0);
        checkOutput("cancel run hi", 64'(hi), 64'(modelHi));
        checkOutput("cancel run lo", 64'(lo), 64'(modelLo));
        noDoneFor("cancel run", 40);

        // A start raised mid-RUN must neither restart nor alter the in-flight multiply.
        applyStimulus(FN_MULTU, 32'd6, 32'd7);
        repeat (3) tick();
        start  = 1'b1;
        fncode = FN_MTLO;
        op_a   = 32'h0BAD;
        op_b   = 32'h0BAD;
        repeat (2) tick();
        start  = 1'b0;
        waitDone("ignored start", 28, 32'd0, 32'd42);
        tick();

        applyStimulus(FN_MULTU, 32'd9, 32'd9);
        repeat (32) tick();
        checkOutput("fix busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checkOutput("cancel fix busy", 64'(busy), 64'd0);
        checkOutput("cancel fix done", 64'(done), 64'd0);
        checkOutput("cancel fix lo", 64'(lo), 64'(modelLo));
        noDoneFor("cancel fix", 5);

        applyStimulus(FN_MULTU, 32'd11, 32'd13);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset busy", 64'(busy), 64'd0);
        checkOutput("async reset done", 64'(done), 64'd0);
        checkOutput("async reset hi", 64'(hi), 64'd0);
        checkOutput("async reset lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        tick();
        noDoneFor("after reset", 40);
        checkOutput("after reset lo", 64'(lo), 64'd0);

        applyStimulus(FN_DIVU, 32'd100, 32'd10);
        waitDone("post reset divu", 33, 32'd0, 32'd10);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
